// File: rtl/inout_sram_arbiter_pkg.sv
// Shared constants, state encoding and bank-range helper for the InOut SRAM arbiter.
package inout_arb_pkg;

  localparam int NUM_BANKS    = 6;
  localparam int BANK_SEL_MSB = 17;
  localparam int BANK_SEL_LSB = 15;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

  // Banks 6 and 7 of the 3-bit bank field do not exist in the 384 kB array.
  function automatic logic in_range(input logic [BANK_SEL_MSB:0] addr);
    logic [BANK_SEL_MSB-BANK_SEL_LSB:0] bank;
    bank = addr[BANK_SEL_MSB:BANK_SEL_LSB];
    return (bank < 3'(NUM_BANKS));
  endfunction

endpackage

// File: rtl/inout_sram_arbiter_rr_picker.sv
// Round-robin one-hot picker: first requesting index at or after start_i, wrapping.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan N positions starting at start_i; the first hit wins.
  always_comb begin
    int j;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(start_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/inout_sram_arbiter.sv
// Round-robin arbiter for one InOut SRAM port with locked bursts, a hold
// limit, bank range rejection and one-cycle tagged responses.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ARB_IDLE   | no owner; grant first requester at/after ptr
//   ARB_LOCKED | owner_q keeps the port until lock drops, req drops or
//              | hold_q reaches MAX_HOLD
module inout_sram_arbiter
  import inout_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic                      resp_err,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      mem_cs,
  output logic                      mem_oe,
  output logic                      mem_W_req,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_W_data,
  input  logic [DATA_W-1:0]         mem_R_data
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic                resp_err_q;
  logic                resp_rd_q;

  logic [IW-1:0]       pick_start;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [IW-1:0]       sel_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_we;
  logic                sel_ok;
  logic                accepted;
  logic                unused_rdata_hi;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + IW'(1);
  endfunction

  // A dropped lock re-arbitrates starting just past the old owner.
  assign pick_start = (state_q == ARB_LOCKED) ? next_idx(owner_q) : ptr_q;

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i    (req),
    .start_i  (pick_start),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Grant selection and lock/pointer/hold next-state.
  always_comb begin
    gnt     = '0;
    sel_idx = '0;
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    if (!rstn) begin
      gnt = '0;
    end else if (state_q == ARB_LOCKED && req[owner_q]) begin
      gnt[owner_q] = 1'b1;
      sel_idx      = owner_q;
      if (req_lock[owner_q] && (int'(hold_q) + 1 < MAX_HOLD)) begin
        hold_d = hold_q + HW'(1);
      end else begin
        state_d = ARB_IDLE;
        ptr_d   = next_idx(owner_q);
        hold_d  = '0;
      end
    end else if (pick_any) begin
      gnt     = pick_onehot;
      sel_idx = pick_idx;
      if (req_lock[pick_idx] && MAX_HOLD > 1) begin
        state_d = ARB_LOCKED;
        owner_d = pick_idx;
        hold_d  = HW'(1);
        ptr_d   = pick_start;
      end else begin
        state_d = ARB_IDLE;
        ptr_d   = next_idx(pick_idx);
        hold_d  = '0;
      end
    end else begin
      state_d = ARB_IDLE;
      ptr_d   = pick_start;
      hold_d  = '0;
    end
  end

  // Memory port mux; address and write data hold when the port is idle.
  always_comb begin
    accepted   = |gnt;
    sel_addr   = req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
    sel_we     = req_we[sel_idx];
    sel_ok     = in_range(sel_addr[BANK_SEL_MSB:0]);
    mem_cs     = accepted & sel_ok;
    mem_oe     = mem_cs & ~sel_we;
    mem_W_req  = ~(mem_cs & sel_we);
    mem_addr   = accepted ? sel_addr : mem_addr_q;
    mem_W_data = accepted ? req_wdata[int'(sel_idx)*DATA_W +: DATA_W] : mem_wdata_q;
  end

  // Arbiter state, held memory bus and the one-cycle response register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ARB_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      hold_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= '0;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      hold_q       <= hold_d;
      mem_addr_q   <= mem_addr;
      mem_wdata_q  <= mem_W_data;
      resp_valid_q <= gnt;
      resp_err_q   <= accepted & ~sel_ok;
      resp_rd_q    <= mem_oe;
    end
  end

  // The SRAM keeps only 16 bits per word; reads come back sign-extended.
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rd_q ? {{(DATA_W-16){mem_R_data[15]}}, mem_R_data[15:0]} : '0;

  assign unused_rdata_hi = ^mem_R_data[DATA_W-1:16];

endmodule

// File: tb/tb_inout_sram_arbiter.sv
// Scoreboard bench for inout_sram_arbiter with a behavioural SRAM on the port.
module tb_inout_sram_arbiter;

  logic          clk = 1'b0;
  logic          rstn;
  logic [3:0]    req_v, we_v, lock_v;
  logic [31:0]   addr_r [4];
  logic [31:0]   wd_r [4];
  logic [127:0]  req_addr, req_wdata;
  logic [3:0]    gnt, resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_cs, mem_oe, mem_W_req;
  logic [31:0]   mem_addr, mem_W_data, mem_R_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          idx;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mx;

  logic [15:0] sram   [logic [31:0]];
  logic [15:0] shadow [logic [31:0]];

  assign req_addr  = {addr_r[3], addr_r[2], addr_r[1], addr_r[0]};
  assign req_wdata = {wd_r[3], wd_r[2], wd_r[1], wd_r[0]};

  inout_sram_arbiter #(
    .NUM_REQ  (4),
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_HOLD (16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req_v),
    .req_we     (we_v),
    .req_lock   (lock_v),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_cs     (mem_cs),
    .mem_oe     (mem_oe),
    .mem_W_req  (mem_W_req),
    .mem_addr   (mem_addr),
    .mem_W_data (mem_W_data),
    .mem_R_data (mem_R_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten SRAM words read back a recognisable per-address pattern.
  function automatic logic [15:0] dflt(input logic [31:0] a);
    return {~a[7:0], a[7:0]};
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Behavioural SRAM: upper read bits are junk so sign extension is exercised.
  always @(posedge clk) begin
    if (mem_cs && !mem_W_req) sram[mem_addr] = mem_W_data[15:0];
    if (mem_cs && mem_oe)
      mem_R_data <= {16'hDEAD, sram.exists(mem_addr) ? sram[mem_addr] : dflt(mem_addr)};
    else
      mem_R_data <= 32'hDEADBEEF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One beat: e is the requester expected to win, -1 for no grant.
  task automatic step(input int e);
    exp_t        x;
    logic [31:0] a;
    logic [3:0]  eg;
    @(negedge clk);
    eg = (e < 0) ? 4'b0000 : 4'(1 << e);
    chk("gnt", gnt, eg);
    if (e < 0) begin
      chk("idle_mem_ctrl", {mem_cs, mem_oe, mem_W_req}, 3'b001);
    end else begin
      a     = addr_r[e];
      x.idx = e;
      x.err = (a[17:15] >= 3'd6);
      x.cyc = cyc + 1;
      chk("mem_cs", mem_cs, !x.err);
      if (!x.err) begin
        chk("mem_addr", mem_addr, a);
        chk("mem_W_req", mem_W_req, !we_v[e]);
      end
      if (x.err || we_v[e]) x.rdata = '0;
      else x.rdata = sext(shadow.exists(a) ? shadow[a] : dflt(a));
      if (!x.err && we_v[e]) shadow[a] = wd_r[e][15:0];
      q.push_back(x);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response strobe is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid != 4'b0000) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", resp_valid, 0);
      end else begin
        mx = q.pop_front();
        chk("resp_cycle", cyc, mx.cyc);
        chk("resp_valid", resp_valid, 1 << mx.idx);
        chk("resp_err", resp_err, mx.err);
        chk("resp_rdata", resp_rdata, mx.rdata);
      end
    end
  end

  initial begin
    rstn   = 1'b0;
    req_v  = 4'hF;
    we_v   = 4'h0;
    lock_v = 4'h0;
    for (int i = 0; i < 4; i++) begin
      addr_r[i] = 32'h100 + i;
      wd_r[i]   = '0;
    end

    // Reset with everyone requesting.
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_gnt", gnt, 0);
    @(posedge clk);
    #1;
    step(-1);
    step(-1);
    rstn = 1'b1;

    // Fairness: four readers, no locks.
    for (int k = 0; k < 20; k++) begin
      addr_r[k % 4] = 32'h100 + k;
      step(k % 4);
    end

    // Move the pointer to 2, then a 6-beat locked write burst from requester 2.
    req_v = 4'b0010;
    addr_r[1] = 32'h0;
    step(1);
    req_v = 4'hF;
    we_v  = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      addr_r[2] = 32'h10 + k;
      wd_r[2]   = {16'hABCD, (k % 2 == 1) ? 16'h0123 + 16'(k) : 16'hF000 + 16'(k)};
      lock_v    = (k < 5) ? 4'b0100 : 4'b0000;
      step(2);
    end
    we_v = 4'h0;
    step(3);
    step(0);
    step(1);

    // Burst readback and write-then-read on consecutive beats.
    req_v = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      addr_r[2] = 32'h10 + k;
      step(2);
    end
    req_v     = 4'b0001;
    we_v      = 4'b0001;
    addr_r[0] = 32'h40;
    wd_r[0]   = 32'h5A5A7777;
    step(0);
    we_v = 4'h0;
    step(0);

    // Hold limit: requester 1 locked forever with everyone else waiting.
    req_v  = 4'hF;
    lock_v = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      addr_r[1] = 32'h200 + k;
      step(1);
    end
    step(2);
    step(3);
    step(0);
    step(1);
    req_v = 4'b1101;
    step(2);
    lock_v = 4'h0;

    // Out-of-range banks 6 and 7, then the last word of bank 5.
    req_v     = 4'b1000;
    addr_r[3] = 32'h30000;
    step(3);
    we_v      = 4'b1000;
    addr_r[3] = 32'h38000;
    wd_r[3]   = 32'h00001234;
    step(3);
    we_v      = 4'h0;
    addr_r[3] = 32'h2FFFF;
    step(3);

    // Reset in the middle of a locked burst.
    we_v      = 4'b1000;
    lock_v    = 4'b1000;
    addr_r[3] = 32'h50;
    wd_r[3]   = 32'h00001111;
    step(3);
    addr_r[3] = 32'h51;
    step(3);
    rstn  = 1'b0;
    req_v = 4'b1010;
    step(-1);
    rstn   = 1'b1;
    lock_v = 4'h0;
    we_v   = 4'h0;
    addr_r[1] = 32'h51;
    addr_r[3] = 32'h50;
    step(1);
    step(3);

    req_v = 4'h0;
    step(-1);
    step(-1);
    chk("pending_responses", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
